reg_file_mp: RTL

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_pkg.sv | 10 +
 rtl/reg_file_clr_seq.sv | 56 +++++
 rtl/reg_file_mp.sv | 73 +++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and default widths for the multi-port register file.
package reg_file_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;
endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear-sweep sequencer: walks every entry once after reset or a clr pulse.
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  output logic              ready_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output state_e            state_o
);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              ready_q;

  // The counter wrap from all-ones back to zero lines up with the return to IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= CLEAR;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign clr_we_o   = (state_q == CLEAR);
  assign clr_addr_o = cnt_q;
  assign state_o    = state_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with a sequenced clear sweep.
// Optional write-to-read forwarding is enabled by defining REG_FILE_MP_BYPASS_EN.
// Handshake: writes are accepted and rdata is meaningful only while ready=1;
// while ready=0 (sweep in progress) writes are dropped and every rdata port is 0.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic                  clr,
  output logic                  ready,
  output state_e                dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_en;

  reg_file_clr_seq #(
    .ADDR_W(ADDR_W)
  ) u_clr_seq (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clr_i     (clr),
    .ready_o   (ready),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr),
    .state_o   (dbg_state)
  );

  assign wr_en = ready && we && !((ZERO_R0 != 0) && (waddr == '0));

  // Storage has no reset of its own; zeroing comes only from the sweep.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_en) begin
      mem_q[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd = mem_q[ra];
`ifdef REG_FILE_MP_BYPASS_EN
      if (wr_en && (ra == waddr)) rd = wdata;
`else
`endif
      if (!ready || ((ZERO_R0 != 0) && (ra == '0))) rd = '0;
    end

    assign rdata[k*DATA_W +: DATA_W] = rd;
  end

endmodule
